// File: rtl/pong_hit_score.sv
// pong_hit_score -- Pong referee stage.
// Watches ball and paddle positions, emits the one-cycle paddle-hit and
// point-scored pulses for the ball block, keeps both scores and flags game over.
// Optional build macro: PONG_HIT_HOLDOFF_EN adds a post-hit holdoff counter
// that ignores further hits for HIT_HOLDOFF cycles.
module pong_hit_score #(
   parameter int PADDLE1_X     = 1,
   parameter int PADDLE2_X     = 38,
   parameter int BALL_X_MIN    = 0,
   parameter int BALL_X_MAX    = 39,
   parameter int PADDLE_HEIGHT = 6,
   parameter int SCORE_WIN     = 9,
   parameter int SCORE_W       = 4,
   parameter int HIT_HOLDOFF   = 4
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   input  logic [10:0]        i_Ball_X,
   input  logic [10:0]        i_Ball_Y,
   input  logic               i_Ball_Dir,
   input  logic [10:0]        i_Paddle1_Y,
   input  logic [10:0]        i_Paddle2_Y,
   input  logic               i_Space,
   output logic               o_Paddle_Hit,
   output logic               o_Win,
   output logic [SCORE_W-1:0] o_P1_Score,
   output logic [SCORE_W-1:0] o_P2_Score,
   output logic               o_Game_Over,
   output logic               o_Winner
);

   // Reject parameter sets the counters cannot represent.
   if (SCORE_WIN >= (1 << SCORE_W) || HIT_HOLDOFF < 0) begin : g_bad_params
      $error("pong_hit_score: SCORE_W too narrow for SCORE_WIN, or HIT_HOLDOFF negative");
   end

   typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_t;

   state_t             state, state_next;
   logic               space_q;
   logic               scorer, scorer_next;   // 0 = left player scored last, 1 = right
   logic               hit_next, win_next, game_over_next, winner_next;
   logic [SCORE_W-1:0] p1_next, p2_next;
   logic               hit_armed;
   logic               left_hit, right_hit, left_miss, right_miss;
   logic               left_in_range, right_in_range;
   logic [11:0]        ball_y_w, p1_top_w, p2_top_w;

   // Widen to 12 bits so paddle_Y + PADDLE_HEIGHT cannot wrap near the top of the range.
   assign ball_y_w       = {1'b0, i_Ball_Y};
   assign p1_top_w       = {1'b0, i_Paddle1_Y};
   assign p2_top_w       = {1'b0, i_Paddle2_Y};
   assign left_in_range  = (ball_y_w >= p1_top_w) && (ball_y_w < p1_top_w + 12'(PADDLE_HEIGHT));
   assign right_in_range = (ball_y_w >= p2_top_w) && (ball_y_w < p2_top_w + 12'(PADDLE_HEIGHT));

   assign left_hit   = !i_Ball_Dir && (i_Ball_X == 11'(PADDLE1_X + 1)) && left_in_range  && hit_armed;
   assign right_hit  =  i_Ball_Dir && (i_Ball_X == 11'(PADDLE2_X - 1)) && right_in_range && hit_armed;
   assign left_miss  = !i_Ball_Dir && (i_Ball_X <= 11'(BALL_X_MIN));
   assign right_miss =  i_Ball_Dir && (i_Ball_X >= 11'(BALL_X_MAX));

`ifdef PONG_HIT_HOLDOFF_EN
   localparam int HOLD_W = (HIT_HOLDOFF > 1) ? $clog2(HIT_HOLDOFF + 1) : 1;

   logic [HOLD_W-1:0] holdoff, holdoff_next;

   assign hit_armed = (holdoff == '0);

   // Holdoff next value: reload on an accepted hit, otherwise count down to 0.
   always_comb begin
      holdoff_next = (holdoff != '0) ? holdoff - 1'b1 : '0;
      if (state == PLAY && (left_hit || right_hit)) begin
         holdoff_next = HOLD_W'(HIT_HOLDOFF);
      end
   end

   // Holdoff counter register.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) holdoff <= '0;
      else         holdoff <= holdoff_next;
   end
`else
   // Without the counter every cycle that meets the hit geometry is a hit.
   assign hit_armed = 1'b1;
`endif

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= SCORE_W'(SCORE_WIN)) ? s : s + 1'b1;
   endfunction

   // Next-state and next-output logic for the referee FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_next     = state;
      hit_next       = 1'b0;
      win_next       = 1'b0;
      p1_next        = o_P1_Score;
      p2_next        = o_P2_Score;
      game_over_next = o_Game_Over;
      winner_next    = o_Winner;
      scorer_next    = scorer;
      case (state)
         IDLE: begin
            if (i_Space) state_next = PLAY;
         end
         PLAY: begin
            if (left_hit || right_hit) begin
               hit_next = 1'b1;
            end else if (left_miss) begin
               p2_next     = sat_inc(o_P2_Score);
               win_next    = 1'b1;
               scorer_next = 1'b1;
               state_next  = POINT;
            end else if (right_miss) begin
               p1_next     = sat_inc(o_P1_Score);
               win_next    = 1'b1;
               scorer_next = 1'b0;
               state_next  = POINT;
            end
         end
         POINT: begin
            // The score was bumped on entry to POINT; decide whether it ended the game.
            if ((scorer ? o_P2_Score : o_P1_Score) == SCORE_W'(SCORE_WIN)) begin
               game_over_next = 1'b1;
               winner_next    = scorer;
               state_next     = OVER;
            end else begin
               state_next = IDLE;
            end
         end
         OVER: begin
            // Only a fresh press restarts; a key held since before game over does not.
            if (i_Space && !space_q) begin
               p1_next        = '0;
               p2_next        = '0;
               game_over_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_Clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_Reset) state <= IDLE;
      else         state <= state_next;
   end

   // Registered outputs, scores and key history.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         o_Paddle_Hit <= 1'b0;
         o_Win        <= 1'b0;
         o_P1_Score   <= '0;
         o_P2_Score   <= '0;
         o_Game_Over  <= 1'b0;
         o_Winner     <= 1'b0;
         scorer       <= 1'b0;
         space_q      <= 1'b0;
      end else begin
         o_Paddle_Hit <= hit_next;
         o_Win        <= win_next;
         o_P1_Score   <= p1_next;
         o_P2_Score   <= p2_next;
         o_Game_Over  <= game_over_next;
         o_Winner     <= winner_next;
         scorer       <= scorer_next;
         space_q      <= i_Space;
      end
   end

endmodule
